// File: rtl/top_sdiv_pkg.sv
// Shared types and constants for the 16s / 8s sequential signed divider.
package top_sdiv_pkg;

    localparam int unsigned DIV_Q_W = 16;
    localparam int unsigned DIV_R_W = 8;

    localparam logic [DIV_Q_W-1:0] Q_POS_SAT = 16'h7FFF;
    localparam logic [DIV_Q_W-1:0] Q_NEG_SAT = 16'h8000;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

endpackage

// File: rtl/top_sdiv_16s_8s_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
interface top_sdiv_16s_8s_seq_if;
    import top_sdiv_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [DIV_Q_W-1:0] din0;
    logic [DIV_R_W-1:0] din1;
    logic               out_valid;
    logic               out_ready;
    logic [DIV_Q_W-1:0] quot;
    logic [DIV_R_W-1:0] rem;
    logic               dbz;
    logic               ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, dbz, ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, dbz, ovf
    );

endinterface

// File: rtl/top_sdiv_step.sv
// One combinational restoring-division step on magnitudes: shift in a dividend bit,
// compare against the divisor, subtract when it fits and emit the quotient bit.
module top_sdiv_step (
    input  logic [8:0] rem_in,
    input  logic       dvd_bit,
    input  logic [8:0] dvs,
    output logic [8:0] rem_out,
    output logic       q_bit
);

    logic [9:0] partial;
    logic [9:0] diff;

    always_comb begin
        partial = {rem_in, dvd_bit};
        diff    = partial - {1'b0, dvs};
        q_bit   = (partial >= {1'b0, dvs});
        // Either branch fits in 9 bits because the remainder stays below the divisor.
        rem_out = q_bit ? diff[8:0] : partial[8:0];
    end

endmodule

// File: rtl/top_sdiv_16s_8s_seq.sv
// Sequential 16s / 8s signed divider, one quotient bit per cycle, valid/ready on both sides.
// Optional early exit for trivial operands when TOP_SDIV_EARLY_TERM_EN is defined.
module top_sdiv_16s_8s_seq
    import top_sdiv_pkg::*;
#(
    parameter int unsigned ID         = 1,
    parameter int unsigned DIN0_WIDTH = 16,
    parameter int unsigned DIN1_WIDTH = 8
) (
    input logic                  ap_clk,
    input logic                  ap_rst,
    top_sdiv_16s_8s_seq_if.slave bus
);

    state_e state_q, state_d;

    logic [DIV_Q_W-1:0] dvd_mag_q;
    logic [8:0]         dvs_mag_q;
    logic               sgn_dvd_q;
    logic               sgn_dvs_q;
    logic [3:0]         cnt_q;
    logic [8:0]         prem_q;
    logic [DIV_Q_W-1:0] qmag_q;
    logic               dbz_q;
    logic               ovf_q;
    logic [DIV_Q_W-1:0] quot_q;
    logic [DIV_R_W-1:0] rem_q;

    logic [16:0]        din0_ext, din0_mag;
    logic [8:0]         din1_ext, din1_mag;
    logic               dbz_in, ovf_in, take;
    logic [8:0]         step_rem;
    logic               step_q;
    logic [DIV_Q_W-1:0] q_fix;
    logic [DIV_R_W-1:0] r_fix;
    logic               unused_cfg;

    assign unused_cfg = ^{ID[0], DIN0_WIDTH[0], DIN1_WIDTH[0], din0_mag[16]};

    always_comb begin
        din0_ext = {bus.din0[DIV_Q_W-1], bus.din0};
        din1_ext = {bus.din1[DIV_R_W-1], bus.din1};
        din0_mag = bus.din0[DIV_Q_W-1] ? (~din0_ext + 17'd1) : din0_ext;
        din1_mag = bus.din1[DIV_R_W-1] ? (~din1_ext + 9'd1) : din1_ext;
        dbz_in   = (bus.din1 == '0);
        ovf_in   = (bus.din0 == Q_NEG_SAT) && (bus.din1 == 8'hFF);
        take     = bus.in_valid && (state_q == StIdle);
    end

`ifdef TOP_SDIV_EARLY_TERM_EN
    logic early_small, early_exit;
    assign early_small = (din0_mag < {8'b0, din1_mag});
    assign early_exit  = dbz_in || ovf_in || early_small;
`endif

    top_sdiv_step u_step (
        .rem_in  (prem_q),
        .dvd_bit (dvd_mag_q[DIV_Q_W-1]),
        .dvs     (dvs_mag_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take) begin
`ifdef TOP_SDIV_EARLY_TERM_EN
                    state_d = early_exit ? StFix : StCalc;
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc: if (cnt_q == 4'd0) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sign fix-up; saturating overrides win, divide-by-zero before overflow.
    always_comb begin
        q_fix = (sgn_dvd_q ^ sgn_dvs_q) ? (~qmag_q + 16'd1) : qmag_q;
        r_fix = sgn_dvd_q ? (~prem_q[7:0] + 8'd1) : prem_q[7:0];
        if (dbz_q) begin
            q_fix = sgn_dvd_q ? Q_NEG_SAT : Q_POS_SAT;
            r_fix = '0;
        end else if (ovf_q) begin
            q_fix = Q_POS_SAT;
            r_fix = '0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dvd_mag_q <= '0;
            dvs_mag_q <= '0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            cnt_q     <= '0;
            prem_q    <= '0;
            qmag_q    <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (take) begin
                        dvd_mag_q <= din0_mag[DIV_Q_W-1:0];
                        dvs_mag_q <= din1_mag;
                        sgn_dvd_q <= bus.din0[DIV_Q_W-1];
                        sgn_dvs_q <= bus.din1[DIV_R_W-1];
                        dbz_q     <= dbz_in;
                        ovf_q     <= ovf_in;
                        cnt_q     <= 4'd15;
                        qmag_q    <= '0;
`ifdef TOP_SDIV_EARLY_TERM_EN
                        // A dividend smaller than the divisor is its own remainder.
                        prem_q    <= early_small ? din0_mag[8:0] : '0;
`else
                        prem_q    <= '0;
`endif
                    end
                end
                StCalc: begin
                    prem_q    <= step_rem;
                    qmag_q    <= {qmag_q[DIV_Q_W-2:0], step_q};
                    dvd_mag_q <= {dvd_mag_q[DIV_Q_W-2:0], 1'b0};
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                StFix: begin
                    quot_q <= q_fix;
                    rem_q  <= r_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_top_sdiv_16s_8s_seq.sv
// Bench for top_sdiv_16s_8s_seq: directed and random operands against an integer-arithmetic model.
module tb_top_sdiv_16s_8s_seq;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    top_sdiv_16s_8s_seq_if bus ();

    top_sdiv_16s_8s_seq #(
        .ID         (1),
        .DIN0_WIDTH (16),
        .DIN1_WIDTH (8)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division truncating toward zero, remainder follows dividend.
    task automatic model(input int a, input int b, output logic [15:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
        int qi;
        int ri;
        dz = (b == 0);
        ov = (a == -32768) && (b == -1);
        if (dz) begin
            qi = (a >= 0) ? 32767 : -32768;
            ri = 0;
        end else if (ov) begin
            qi = 32767;
            ri = 0;
        end else begin
            qi = a / b;
            ri = a % b;
        end
        q   = qi[15:0];
        r   = ri[7:0];
        lat = 18;
`ifdef TOP_SDIV_EARLY_TERM_EN
        if (dz || ov || ((a < 0 ? -a : a) < (b < 0 ? -b : b))) lat = 2;
`endif
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 50) begin
            @(negedge ap_clk);
            cyc++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic signed [15:0] a, input logic signed [7:0] b,
                          input int hold, input string tag);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz, eov;
        int          elat;
        int          cyc;
        bit          seen;
        model(int'(a), int'(b), eq, er, edz, eov, elat);
        wait_ready(tag);
        bus.in_valid = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din0     = 16'($urandom);
        bus.din1     = 8'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge ap_clk);
            cyc++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(elat));
        chk({tag, "_quot"}, 32'(bus.quot), 32'(eq));
        chk({tag, "_rem"}, 32'(bus.rem), 32'(er));
        chk({tag, "_dbz"}, 32'(bus.dbz), 32'(edz));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eov));
        chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge ap_clk);
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_hold_quot"}, 32'(bus.quot), 32'(eq));
            chk({tag, "_hold_rem"}, 32'(bus.rem), 32'(er));
        end
        bus.out_ready = 1'b1;
        @(negedge ap_clk);
        bus.out_ready = 1'b0;
        chk({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic signed [15:0] ra;
        logic signed [7:0]  rb;
        int                 sel;
        int                 vcount;

        bus.in_valid  = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;

        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_quot", 32'(bus.quot), 32'd0);
        chk("reset_rem", 32'(bus.rem), 32'd0);
        chk("reset_dbz", 32'(bus.dbz), 32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);

        run_op(16'sd100, 8'sd7, 0, "p100_d7");
        run_op(-16'sd100, 8'sd7, 0, "n100_d7");
        run_op(16'sd100, -8'sd7, 0, "p100_dn7");
        run_op(-16'sd128, -8'sd128, 0, "n128_dn128");
        run_op(-16'sd32768, -8'sd1, 0, "ovf");
        run_op(16'sd5, 8'sd0, 0, "dbz_pos");
        run_op(-16'sd5, 8'sd0, 0, "dbz_neg");
        run_op(16'sd3, 8'sd100, 0, "small");
        run_op(16'sd1234, -8'sd56, 10, "backpressure");

        // Abandon an operation in the middle of CALC.
        wait_ready("midreset");
        bus.in_valid = 1'b1;
        bus.din0     = 16'sd1000;
        bus.din1     = 8'sd3;
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset_quot", 32'(bus.quot), 32'd0);
        chk("midreset_rem", 32'(bus.rem), 32'd0);
        chk("midreset_dbz", 32'(bus.dbz), 32'd0);
        chk("midreset_ovf", 32'(bus.ovf), 32'd0);
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge ap_clk);
            if (bus.out_valid === 1'b1) vcount++;
        end
        chk("midreset_no_result", 32'(vcount), 32'd0);
        run_op(16'sd32767, 8'sd1, 0, "max_d1");

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            ra  = 16'($urandom);
            rb  = 8'($urandom);
            if (sel == 0) rb = 8'sd0;
            if (sel == 1) rb = -8'sd1;
            if (sel == 2) ra = -16'sd32768;
            if (sel == 3) ra = 16'($signed(8'($urandom)));
            run_op(ra, rb, (n % 7 == 0) ? 3 : 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
